// File: rtl/rgb2gray_pkg.sv
// Shared types for the RGB->gray packetizer: weighting modes, FSM states,
// and the per-mode coefficient table (weights always sum to 256).
package rgb2gray_pkg;

    typedef enum logic [1:0] {
        MODE_BT601 = 2'd0,
        MODE_BT709 = 2'd1,
        MODE_MEAN  = 2'd2,
        MODE_GREEN = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // 9-bit weights: green passthrough needs the full 256.
    typedef struct packed {
        logic [8:0] wr;
        logic [8:0] wg;
        logic [8:0] wb;
    } weights_t;

    function automatic weights_t get_weights(mode_e m);
        weights_t w;
        unique case (m)
            MODE_BT601: w = '{wr: 9'd77, wg: 9'd150, wb: 9'd29};
            MODE_BT709: w = '{wr: 9'd54, wg: 9'd183, wb: 9'd19};
            MODE_MEAN:  w = '{wr: 9'd85, wg: 9'd86,  wb: 9'd85};
            MODE_GREEN: w = '{wr: 9'd0,  wg: 9'd256, wb: 9'd0};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rgb2gray_packetizer_if.sv
// Handshake bundle between the task manager and the packetizer.
// slave: block side (byte input, answer output); master: manager side.
interface rgb2gray_packetizer_if #(
    parameter int DATA_W    = 8,
    parameter int PKT_CNT_W = 12
);
    import rgb2gray_pkg::*;

    logic                 i_tdata_valid;
    logic [DATA_W-1:0]    i_tdata;
    logic                 i_tdata_last;
    logic                 o_tready;
    logic                 i_tmanager_ready;
    logic                 o_tanswer_ready;
    logic [DATA_W-1:0]    o_tanswer_data;
    logic                 o_tanswer_data_last;
    logic [PKT_CNT_W-1:0] o_packet_size_in_bytes;

    modport slave (
        input  i_tdata_valid, i_tdata, i_tdata_last, i_tmanager_ready,
        output o_tready, o_tanswer_ready, o_tanswer_data,
        output o_tanswer_data_last, o_packet_size_in_bytes
    );

    modport master (
        output i_tdata_valid, i_tdata, i_tdata_last, i_tmanager_ready,
        input  o_tready, o_tanswer_ready, o_tanswer_data,
        input  o_tanswer_data_last, o_packet_size_in_bytes
    );

endinterface

// File: rtl/gray_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Ports: clk, rst_n (sync, active-low), wr_en/wr_data, rd_en/rd_data, count, empty.
module gray_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign rd_ok = rd_en & ~empty;
    // A read in the same cycle frees the slot a full FIFO needs.
    assign wr_ok = wr_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/rgb2gray_packetizer.sv
// Byte-serial pixel stream -> weighted gray samples, returned as a framed
// packet with byte count. Ports: i_clk, i_rst (sync, active-low), i_mode,
// bus (slave modport: input bytes, answer bytes, packet size).
// Build option ROUND_NEAREST_EN: round-to-nearest instead of floor.
module rgb2gray_packetizer
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CH_NUM     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_CNT_W  = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    rgb2gray_packetizer_if.slave bus
);
    localparam int IW = 2;
    localparam int PW = DATA_W + 8;
    localparam int SW = DATA_W + 9;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    localparam logic [DATA_W-1:0]    PIX_MAX = '1;
    localparam logic [PKT_CNT_W-1:0] CNT_MAX = '1;

    state_e               state, state_nx;
    mode_e                mode_q, mode_eff;
    weights_t             w;
    logic [8:0]           w_arr [3];
    logic [IW-1:0]        idx;
    logic [DATA_W-1:0]    ch_q [3];
    logic [DATA_W-1:0]    px [3];
    logic [PW-1:0]        prod [3];
    logic                 tready;
    logic                 accept;
    logic                 pix_done;

    logic                 s1_valid, s1_last;
    logic [PW-1:0]        s1_p [3];
    logic                 s2_valid, s2_last;
    logic [DATA_W-1:0]    s2_data;
    logic [SW-1:0]        sum;
    logic [SW-1:0]        shifted;
    logic [DATA_W-1:0]    gray;

    logic [DATA_W:0]      fifo_rd;
    logic [AW:0]          fifo_count;
    logic                 fifo_empty;
    logic [CW-1:0]        pend;
    logic                 ans_valid;
    logic                 ans_hs;
    logic                 fifo_last;

    logic [PKT_CNT_W-1:0] byte_cnt;
    logic [PKT_CNT_W-1:0] cnt_inc;
    logic [PKT_CNT_W-1:0] size_q;

    // Pixels already in the pipe own a FIFO slot, so a write never hits full.
    assign pend   = CW'(fifo_count) + CW'(s1_valid) + CW'(s2_valid);
    assign tready = i_rst & (state != ST_DRAIN) & (pend < CW'(FIFO_DEPTH));
    assign accept = bus.i_tdata_valid & tready;
    assign pix_done = accept &
                      (bus.i_tdata_last | (idx == IW'(CH_NUM - 1)));

    // First byte of a packet uses the live mode; later bytes the latched one.
    assign mode_eff = (state == ST_IDLE) ? mode_e'(i_mode) : mode_q;
    assign w        = get_weights(mode_eff);
    assign w_arr[0] = w.wr;
    assign w_arr[1] = w.wg;
    assign w_arr[2] = w.wb;

    // Assemble R,G,B: earlier bytes from regs, current byte live,
    // channels not yet seen (early last) read as 0. Alpha never used.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            px[c] = '0;
            if (IW'(c) < idx) begin
                px[c] = ch_q[c];
            end else if (IW'(c) == idx) begin
                px[c] = bus.i_tdata;
            end
            prod[c] = PW'(w_arr[c]) * PW'(px[c]);
        end
    end

    always_comb begin
        sum = SW'(s1_p[0]) + SW'(s1_p[1]) + SW'(s1_p[2]);
`ifdef ROUND_NEAREST_EN
        sum     = sum + SW'(128);
        shifted = sum >> 8;
        gray    = (shifted > SW'(PIX_MAX)) ? PIX_MAX : DATA_W'(shifted);
`else
        shifted = sum >> 8;
        gray    = DATA_W'(shifted);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_BT601;
            idx    <= '0;
            for (int c = 0; c < 3; c++) ch_q[c] <= '0;
        end else begin
            state <= state_nx;
            if (accept && state == ST_IDLE) mode_q <= mode_eff;
            if (accept) idx <= pix_done ? '0 : idx + IW'(1);
            for (int c = 0; c < 3; c++) begin
                if (accept && idx == IW'(c)) ch_q[c] <= bus.i_tdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:
                if (accept)
                    state_nx = bus.i_tdata_last ? ST_DRAIN : ST_COLLECT;
            ST_COLLECT:
                if (accept && bus.i_tdata_last) state_nx = ST_DRAIN;
            ST_DRAIN:
                if (ans_hs && fifo_last) state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
            for (int c = 0; c < 3; c++) s1_p[c] <= '0;
        end else begin
            s1_valid <= pix_done;
            s1_last  <= pix_done & bus.i_tdata_last;
            if (pix_done) begin
                for (int c = 0; c < 3; c++) s1_p[c] <= prod[c];
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) s2_data <= gray;
        end
    end

    gray_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .wr_en   (s2_valid),
        .wr_data ({s2_last, s2_data}),
        .rd_en   (ans_hs),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign ans_valid = ~fifo_empty;
    assign fifo_last = fifo_rd[DATA_W];
    assign ans_hs    = ans_valid & bus.i_tmanager_ready;
    assign cnt_inc   = (byte_cnt == CNT_MAX) ? CNT_MAX
                                             : byte_cnt + PKT_CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            byte_cnt <= '0;
            size_q   <= '0;
        end else if (ans_hs) begin
            if (fifo_last) begin
                size_q   <= cnt_inc;
                byte_cnt <= '0;
            end else begin
                byte_cnt <= cnt_inc;
            end
        end
    end

    // Gate with valid so stale FIFO memory never shows on the port.
    assign bus.o_tready               = tready;
    assign bus.o_tanswer_ready        = ans_valid;
    assign bus.o_tanswer_data         = ans_valid ? fifo_rd[DATA_W-1:0] : '0;
    assign bus.o_tanswer_data_last    = ans_valid & fifo_last;
    assign bus.o_packet_size_in_bytes = size_q;

endmodule

// File: tb/tb_rgb2gray_packetizer.sv
// Randomized self-checking bench for rgb2gray_packetizer against
// a packet-level gray model; directed cases for reset and corners.
module tb_rgb2gray_packetizer;
    localparam int DW       = 8;
    localparam int CH       = 3;
    localparam int DEPTH    = 16;
    localparam int CW       = 12;
    localparam int SIZE_MAX = (1 << CW) - 1;
    localparam int BUDGET   = 5000;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ans_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = 2'd0;

    int n_chk  = 0;
    int n_fail = 0;
    int ready_pct = 100;

    ans_t       exp_q [$];
    int         size_q [$];
    logic [7:0] pkt [$];

    bit         size_pend = 1'b0;
    int         exp_size;
    bit         stall_prev = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;
    ans_t       mon_e;

    rgb2gray_packetizer_if #(.DATA_W(DW), .PKT_CNT_W(CW)) bus ();

    rgb2gray_packetizer #(
        .DATA_W     (DW),
        .CH_NUM     (CH),
        .FIFO_DEPTH (DEPTH),
        .PKT_CNT_W  (CW)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_mode (mode),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    endtask

    function automatic int gray_ref(int m, int r, int g, int b);
        int wr, wg, wb, s;
        case (m)
            0:       begin wr = 77; wg = 150; wb = 29; end
            1:       begin wr = 54; wg = 183; wb = 19; end
            2:       begin wr = 85; wg = 86;  wb = 85; end
            default: begin wr = 0;  wg = 256; wb = 0;  end
        endcase
        s = wr * r + wg * g + wb * b;
`ifdef ROUND_NEAREST_EN
        s = (s + 128) / 256;
        if (s > 255) s = 255;
`else
        s = s / 256;
`endif
        return s;
    endfunction

    task automatic push_exp(input int d, input bit l);
        ans_t e;
        e.d = 8'(d);
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic build_expect(input int m);
        int n = 0;
        int len = pkt.size();
        for (int k = 0; k < len; k += CH) begin
            int r, g, b;
            r = pkt[k];
            g = (k + 1 < len) ? int'(pkt[k+1]) : 0;
            b = (k + 2 < len) ? int'(pkt[k+2]) : 0;
            push_exp(gray_ref(m, r, g, b), (k + CH >= len));
            n++;
        end
        size_q.push_back(n > SIZE_MAX ? SIZE_MAX : n);
    endtask

    task automatic fill_random(input int len);
        pkt.delete();
        repeat (len) pkt.push_back(8'($urandom_range(255)));
    endtask

    task automatic put_byte(input logic [7:0] d, input logic l);
        int n = 0;
        bus.i_tdata_valid = 1'b1;
        bus.i_tdata       = d;
        bus.i_tdata_last  = l;
        while (!bus.o_tready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n == BUDGET) begin
            check("tready_timeout", 0, 1);
            finish_run();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_packet(input int m);
        int len = pkt.size();
        for (int i = 0; i < len; i++) begin
            if (i == 0) mode = 2'(m);
            else mode = 2'($urandom_range(3));
            put_byte(pkt[i], (i == len - 1));
        end
        check("drain_blocks_input", bus.o_tready, 0);
        bus.i_tdata_valid = 1'b0;
        bus.i_tdata_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || size_pend) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n == 20000) check("drain_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ans_ready"}, bus.o_tanswer_ready, 0);
        check({tag, "_ans_data"}, bus.o_tanswer_data, 0);
        check({tag, "_ans_last"}, bus.o_tanswer_data_last, 0);
        check({tag, "_pkt_size"}, bus.o_packet_size_in_bytes, 0);
        check({tag, "_tready"}, bus.o_tready, 0);
    endtask

    task automatic do_reset();
        bus.i_tdata_valid = 1'b0;
        bus.i_tdata_last  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        exp_q.delete();
        size_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_tready_after", bus.o_tready, 1);
    endtask

    // Manager model and answer scoreboard.
    always @(negedge clk) begin
        bus.i_tmanager_ready = ($urandom_range(99) < ready_pct);
        if (!rst_n) begin
            stall_prev = 1'b0;
            size_pend  = 1'b0;
        end else begin
            if (size_pend) begin
                check("pkt_size", bus.o_packet_size_in_bytes, exp_size);
                size_pend = 1'b0;
            end
            if (stall_prev) begin
                check("hold_ready", bus.o_tanswer_ready, 1);
                check("hold_data", bus.o_tanswer_data, prev_d);
                check("hold_last", bus.o_tanswer_data_last, prev_l);
            end
            stall_prev = bus.o_tanswer_ready && !bus.i_tmanager_ready;
            prev_d = bus.o_tanswer_data;
            prev_l = bus.o_tanswer_data_last;
            if (bus.o_tanswer_ready && bus.i_tmanager_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_answer", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ans_data", bus.o_tanswer_data, mon_e.d);
                    check("ans_last", bus.o_tanswer_data_last, mon_e.l);
                    if (mon_e.l && size_q.size() != 0) begin
                        exp_size  = size_q.pop_front();
                        size_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int m;
        bus.i_tdata_valid = 1'b0;
        bus.i_tdata       = '0;
        bus.i_tdata_last  = 1'b0;
        bus.i_tmanager_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tready_after", bus.o_tready, 1);

        // White pixel, BT.601: 256*255/256 in both builds.
        pkt = '{8'd255, 8'd255, 8'd255};
        push_exp(255, 1'b1);
        size_q.push_back(1);
        send_packet(0);
        wait_idle();

        // Reset with R,G in flight: next 3-byte packet is one clean pixel.
        mode = 2'd0;
        put_byte(8'd10, 1'b0);
        put_byte(8'd20, 1'b0);
        do_reset();
        pkt = '{8'd30, 8'd60, 8'd90};
`ifdef ROUND_NEAREST_EN
        push_exp(56, 1'b1);
`else
        push_exp(55, 1'b1);
`endif
        size_q.push_back(1);
        send_packet(1);
        wait_idle();

        // BT.601, two pixels.
        pkt = '{8'd100, 8'd50, 8'd200, 8'd0, 8'd255, 8'd0};
        push_exp(82, 1'b0);
        push_exp(149, 1'b1);
        size_q.push_back(2);
        send_packet(0);
        wait_idle();

        // Mean mode, last mid-pixel: second pixel padded to (40,0,0).
        pkt = '{8'd10, 8'd20, 8'd30, 8'd40};
        push_exp(20, 1'b0);
        push_exp(13, 1'b1);
        size_q.push_back(2);
        send_packet(2);
        wait_idle();

        // Backpressure: 64 pixels with the manager stalled.
        ready_pct = 0;
        m = $urandom_range(3);
        fill_random(64 * CH);
        build_expect(m);
        fork
            send_packet(m);
        join_none
        repeat (80) @(negedge clk);
        check("bp_tready_low", bus.o_tready, 0);
        check("bp_answer_pending", bus.o_tanswer_ready, 1);
        ready_pct = 60;
        wait fork;
        wait_idle();

        // Oversized packet: byte count saturates.
        ready_pct = 85;
        m = $urandom_range(3);
        fill_random(13000);
        build_expect(m);
        send_packet(m);
        wait_idle();
        check("sat_size", bus.o_packet_size_in_bytes, SIZE_MAX);

        // Random back-to-back packets.
        for (int p = 0; p < 40; p++) begin
            ready_pct = $urandom_range(20, 100);
            m = $urandom_range(3);
            fill_random($urandom_range(1, 24));
            build_expect(m);
            send_packet(m);
        end
        ready_pct = 100;
        wait_idle();
        check("leftover_answers", exp_q.size(), 0);

        finish_run();
    end

endmodule
